// File: rtl/demux_sync_pkg.sv
// demux_sync_pkg: shared types and constants for the demux_sync handshake splitter.
//   state_t  - FSM state encoding (IDLE, REQ, HOLD, RTZ), 2 bits
//   SYNC_MIN - smallest synchronizer depth that is safe for metastability
package demux_sync_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    RTZ  = 2'd3
  } state_t;

  localparam int SYNC_MIN = 2;

endpackage

// File: rtl/demux_sync_sync_ff.sv
// sync_ff: single-bit multi-flop synchronizer for an asynchronous input.
//   clk  - destination clock
//   rst  - asynchronous active-low reset, clears the whole chain to 0
//   i_d  - asynchronous input bit
//   o_q  - synchronized output (last flop of the chain)
module sync_ff
  import demux_sync_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  // Depths below the minimum are raised so a bad override cannot remove metastability protection.
  localparam int DEPTH_EFF = (DEPTH < SYNC_MIN) ? SYNC_MIN : DEPTH;

  logic [DEPTH_EFF-1:0] r_chain;

  // Shift chain: bit 0 samples the asynchronous input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[DEPTH_EFF-2:0], i_d};
    end
  end

  assign o_q = r_chain[DEPTH_EFF-1];

endmodule

// File: rtl/demux_sync.sv
// demux_sync: clocked 4-phase bundled-data split. One input channel plus a
// dual-rail control token is steered to output channel 0 (ctl_a) or 1 (ctl_b).
//   clk, rst          - clock, asynchronous active-low reset
//   r_i/a_i/d_i       - input channel request / acknowledge / data
//   ctl_a/ctl_b       - dual-rail control rails, actl_i is their acknowledge
//   r_o/a_o/d_o       - output channel 0
//   r1_o/a1_o/d1_o    - output channel 1
//   err               - sticky protocol error flag
module demux_sync
  import demux_sync_pkg::*;
#(
  parameter int N    = 1,
  parameter int SYNC = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         r_i,
  output logic         a_i,
  input  logic [N-1:0] d_i,
  input  logic         ctl_a,
  input  logic         ctl_b,
  output logic         actl_i,
  output logic         r_o,
  input  logic         a_o,
  output logic [N-1:0] d_o,
  output logic         r1_o,
  input  logic         a1_o,
  output logic [N-1:0] d1_o,
  output logic         err
);

  state_t       r_state;
  state_t       w_next;
  logic         r_sel;
  logic [N-1:0] r_dreg;
  logic         r_req0;
  logic         r_req1;
  logic         r_ack;
  logic         r_err;

  logic w_rs, w_cas, w_cbs, w_aos, w_a1s;
  logic w_capture;
  logic w_sel_ack;
  logic w_req_nxt;
  logic w_ack_nxt;
  logic w_err_set;

  sync_ff #(.DEPTH(SYNC)) u_sync_r   (.clk(clk), .rst(rst), .i_d(r_i),   .o_q(w_rs));
  sync_ff #(.DEPTH(SYNC)) u_sync_ca  (.clk(clk), .rst(rst), .i_d(ctl_a), .o_q(w_cas));
  sync_ff #(.DEPTH(SYNC)) u_sync_cb  (.clk(clk), .rst(rst), .i_d(ctl_b), .o_q(w_cbs));
  sync_ff #(.DEPTH(SYNC)) u_sync_ao  (.clk(clk), .rst(rst), .i_d(a_o),   .o_q(w_aos));
  sync_ff #(.DEPTH(SYNC)) u_sync_a1o (.clk(clk), .rst(rst), .i_d(a1_o),  .o_q(w_a1s));

  // A token is ready once the request is present with a legal one-hot control code.
  assign w_capture = w_rs & (w_cas ^ w_cbs);
  // Only the ack of the channel we steered to is ever looked at.
  assign w_sel_ack = r_sel ? w_a1s : w_aos;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_capture) w_next = REQ;
        else           w_next = IDLE;
      end
      REQ: begin
        if (w_sel_ack) w_next = HOLD;
        else           w_next = REQ;
      end
      HOLD: begin
        if (!w_rs && !w_cas && !w_cbs) w_next = RTZ;
        else                           w_next = HOLD;
      end
      RTZ: begin
        if (!w_sel_ack) w_next = IDLE;
        else            w_next = RTZ;
      end
      default: w_next = IDLE;
    endcase
  end

  // Output decode, computed one cycle ahead so all outputs come straight from flops.
  always_comb begin
    w_req_nxt = 1'b0;
    w_ack_nxt = 1'b0;
    w_err_set = 1'b0;
    // Request is excluded on the capture edge itself, giving data a full clock of setup.
    if (((r_state == REQ) || (r_state == HOLD)) && ((w_next == REQ) || (w_next == HOLD))) begin
      w_req_nxt = 1'b1;
    end else begin
      w_req_nxt = 1'b0;
    end
    if ((w_next == HOLD) || (w_next == RTZ)) begin
      w_ack_nxt = 1'b1;
    end else begin
      w_ack_nxt = 1'b0;
    end
    // Illegal dual-rail code while idle, or input request withdrawn before it was acknowledged.
    if (((r_state == IDLE) && w_cas && w_cbs) || ((r_state == REQ) && !w_rs)) begin
      w_err_set = 1'b1;
    end else begin
      w_err_set = 1'b0;
    end
  end

  // Registered outputs, data register and route select.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req0 <= 1'b0;
      r_req1 <= 1'b0;
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_sel  <= 1'b0;
      r_dreg <= '0;
    end else begin
      r_req0 <= w_req_nxt & ~r_sel;
      r_req1 <= w_req_nxt & r_sel;
      r_ack  <= w_ack_nxt;
      r_err  <= r_err | w_err_set;
      // d_i is stable here because the synchronized request is already high.
      if ((r_state == IDLE) && w_capture) begin
        r_dreg <= d_i;
        r_sel  <= w_cbs;
      end else begin
        r_dreg <= r_dreg;
        r_sel  <= r_sel;
      end
    end
  end

  assign r_o    = r_req0;
  assign r1_o   = r_req1;
  assign a_i    = r_ack;
  assign actl_i = r_ack;
  assign d_o    = r_dreg;
  assign d1_o   = r_dreg;
  assign err    = r_err;

endmodule
